// File: rtl/bsg_counter_clear_up_down_multi_sat_pkg.sv
// Purpose : width helpers shared by the up/down multi-port counter and its
//           popcount sub-block. Elaboration-time functions only.
// Contents: safe_clog2, bsg_width, max3
package bsg_counter_clear_up_down_multi_sat_pkg;

  // Bits needed to index x distinct values; never less than 1.
  function automatic int unsigned safe_clog2(input int unsigned x);
    if (x <= 1) return 1;
    return $clog2(x);
  endfunction

  // Bits needed to hold the value x itself (0..x).
  function automatic int unsigned bsg_width(input int unsigned x);
    return safe_clog2(x + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up_down_multi_sat_popcount.sv
// Purpose : combinational population count of a request vector.
// Ports   : i_bits  in  els_p    request bits
//           o_count out width_p  number of set bits in i_bits
module bsg_counter_clear_up_down_multi_sat_popcount #(
  parameter int els_p   = 1,
  parameter int width_p = 1
) (
  input  logic [els_p-1:0]   i_bits,
  output logic [width_p-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      o_count = o_count + width_p'(i_bits[i]);
    end
  end

endmodule

// File: rtl/bsg_counter_clear_up_down_multi_sat.sv
// Purpose : up/down occupancy/credit counter. Each cycle adds popcount(up_i)
//           and subtracts popcount(down_i) from the (optionally cleared)
//           count, saturating or wrapping at the range 0..max_val_p, with
//           sticky overflow/underflow flags and a registered threshold flag.
// Ports   : clk_i          in   1             clock
//           reset_i        in   1             synchronous reset, active-high
//           clear_i        in   1             zero count and flags before up/down
//           up_i           in   up_els_p      increment requests
//           down_i         in   down_els_p    decrement requests
//           count_r_o      out  ptr_width_lp  registered count
//           at_thresh_r_o  out  1             registered count >= thresh_p
//           overflow_r_o   out  1             sticky overflow
//           underflow_r_o  out  1             sticky underflow
module bsg_counter_clear_up_down_multi_sat
  import bsg_counter_clear_up_down_multi_sat_pkg::*;
#(
  parameter int max_val_p    = 1,
  parameter int init_val_p   = 0,
  parameter int up_els_p     = 1,
  parameter int down_els_p   = 1,
  parameter int saturate_p   = 1,
  parameter int thresh_p     = max_val_p,
  parameter int ptr_width_lp = int'(safe_clog2(max_val_p + 1))
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic [up_els_p-1:0]     up_i,
  input  logic [down_els_p-1:0]   down_i,
  output logic [ptr_width_lp-1:0] count_r_o,
  output logic                    at_thresh_r_o,
  output logic                    overflow_r_o,
  output logic                    underflow_r_o
);

  localparam int up_w_lp   = int'(bsg_width(up_els_p));
  localparam int down_w_lp = int'(bsg_width(down_els_p));
  // Two guard bits: one for the carry above max_val_p, one for the sign.
  localparam int calc_w_lp = int'(max3(ptr_width_lp, up_w_lp, down_w_lp)) + 2;

  localparam logic signed [calc_w_lp-1:0] MaxS    = calc_w_lp'(max_val_p);
  localparam logic signed [calc_w_lp-1:0] ModS    = calc_w_lp'(max_val_p + 1);
  localparam logic signed [calc_w_lp-1:0] ThreshS = calc_w_lp'(thresh_p);
  localparam logic                        InitAtThresh = (init_val_p >= thresh_p);

  logic [ptr_width_lp-1:0]        r_count;
  logic                           r_at_thresh;
  logic                           r_overflow;
  logic                           r_underflow;

  logic [up_w_lp-1:0]             w_up_cnt;
  logic [down_w_lp-1:0]           w_down_cnt;
  logic signed [calc_w_lp-1:0]    w_base;
  logic signed [calc_w_lp-1:0]    w_raw;
  logic signed [calc_w_lp-1:0]    w_next;
  logic                           w_ovf_evt;
  logic                           w_unf_evt;

  bsg_counter_clear_up_down_multi_sat_popcount #(
    .els_p   (up_els_p),
    .width_p (up_w_lp)
  ) u_pop_up (
    .i_bits  (up_i),
    .o_count (w_up_cnt)
  );

  bsg_counter_clear_up_down_multi_sat_popcount #(
    .els_p   (down_els_p),
    .width_p (down_w_lp)
  ) u_pop_down (
    .i_bits  (down_i),
    .o_count (w_down_cnt)
  );

  always_comb begin
    w_base    = clear_i ? '0 : calc_w_lp'(r_count);
    w_raw     = w_base + calc_w_lp'(w_up_cnt) - calc_w_lp'(w_down_cnt);
    w_unf_evt = w_raw[calc_w_lp-1];
    w_ovf_evt = !w_unf_evt && (w_raw > MaxS);
    w_next    = w_raw;
    if (saturate_p != 0) begin
      if (w_ovf_evt)      w_next = MaxS;
      else if (w_unf_evt) w_next = '0;
    end else begin
      // The els bounds keep |raw excursion| <= max_val_p+1, so one
      // modulus correction always lands back in range.
      if (w_ovf_evt)      w_next = w_raw - ModS;
      else if (w_unf_evt) w_next = w_raw + ModS;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count     <= ptr_width_lp'(init_val_p);
      r_at_thresh <= InitAtThresh;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_next[ptr_width_lp-1:0];
      // Threshold is derived from the next count so it lines up with count_r_o.
      r_at_thresh <= (w_next >= ThreshS);
      r_overflow  <= (r_overflow  & ~clear_i) | w_ovf_evt;
      r_underflow <= (r_underflow & ~clear_i) | w_unf_evt;
    end
  end

  assign count_r_o     = r_count;
  assign at_thresh_r_o = r_at_thresh;
  assign overflow_r_o  = r_overflow;
  assign underflow_r_o = r_underflow;

endmodule

// File: tb/tb_bsg_counter_clear_up_down_multi_sat.sv
// Bench for bsg_counter_clear_up_down_multi_sat: six parameterisations driven
// by a shared stimulus, each compared every cycle against an integer model.
module tb_bsg_counter_clear_up_down_multi_sat;

  localparam int N = 6;
  //                          A   B   C   D   E   F
  localparam int PM [N] = '{  7,  7,  1, 12, 12,  1};
  localparam int PS [N] = '{  1,  0,  0,  0,  1,  1};
  localparam int PI [N] = '{  5,  5,  0,  3, 12,  1};
  localparam int PT [N] = '{  4,  4,  1,  9, 12,  1};
  localparam int PU [N] = '{  3,  3,  2,  5,  8,  1};
  localparam int PD [N] = '{  2,  2,  2,  4,  6,  2};
  localparam int PW [N] = '{  3,  3,  1,  4,  4,  1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] up_s = '0;
  logic [7:0] dn_s = '0;

  logic [3:0] d_cnt [N];
  logic       d_th  [N];
  logic       d_ovf [N];
  logic       d_unf [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [PW[g]-1:0] w_cnt;
    logic             w_th, w_o, w_u;
    bsg_counter_clear_up_down_multi_sat #(
      .max_val_p  (PM[g]),
      .init_val_p (PI[g]),
      .up_els_p   (PU[g]),
      .down_els_p (PD[g]),
      .saturate_p (PS[g]),
      .thresh_p   (PT[g])
    ) u_dut (
      .clk_i         (clk),
      .reset_i       (rst),
      .clear_i       (clr),
      .up_i          (up_s[PU[g]-1:0]),
      .down_i        (dn_s[PD[g]-1:0]),
      .count_r_o     (w_cnt),
      .at_thresh_r_o (w_th),
      .overflow_r_o  (w_o),
      .underflow_r_o (w_u)
    );
    assign d_cnt[g] = 4'(w_cnt);
    assign d_th[g]  = w_th;
    assign d_ovf[g] = w_o;
    assign d_unf[g] = w_u;
  end

  int m_cnt [N];
  bit m_o   [N];
  bit m_u   [N];

  int n_vec = 0;
  int n_err = 0;

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      int         base, raw, pu, pd;
      bit         eo, eu;
      logic [7:0] mu, md;
      if (rst) begin
        m_cnt[k] = PI[k];
        m_o[k]   = 1'b0;
        m_u[k]   = 1'b0;
      end else begin
        mu   = 8'((1 << PU[k]) - 1);
        md   = 8'((1 << PD[k]) - 1);
        pu   = $countones(up_s & mu);
        pd   = $countones(dn_s & md);
        base = clr ? 0 : m_cnt[k];
        raw  = base + pu - pd;
        eo   = raw > PM[k];
        eu   = raw < 0;
        if (PS[k] != 0) m_cnt[k] = eo ? PM[k] : (eu ? 0 : raw);
        else             m_cnt[k] = eo ? raw - (PM[k] + 1) : (eu ? raw + PM[k] + 1 : raw);
        m_o[k] = (clr ? 1'b0 : m_o[k]) | eo;
        m_u[k] = (clr ? 1'b0 : m_u[k]) | eu;
      end
    end
  endtask

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk("count",     k, int'(d_cnt[k]), m_cnt[k]);
      chk("at_thresh", k, int'(d_th[k]),  int'(m_cnt[k] >= PT[k]));
      chk("overflow",  k, int'(d_ovf[k]), int'(m_o[k]));
      chk("underflow", k, int'(d_unf[k]), int'(m_u[k]));
    end
  endtask

  task automatic step(input bit r, input bit c, input logic [7:0] u, input logic [7:0] d);
    rst  = r;
    clr  = c;
    up_s = u;
    dn_s = d;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int mode;
    bit r, c;
    logic [7:0] u, d;

    // Reset, two cycles: A comes up at init 5, above threshold 4.
    step(1, 0, 8'h00, 8'h00);
    step(1, 0, 8'h00, 8'h00);
    chk("lit_rst_cnt", 0, int'(d_cnt[0]), 5);
    chk("lit_rst_th",  0, int'(d_th[0]),  1);
    chk("lit_rst_ovf", 0, int'(d_ovf[0]), 0);
    chk("lit_rst_unf", 0, int'(d_unf[0]), 0);

    // Saturating overflow then hold.
    step(0, 0, 8'b111, 8'h00);
    chk("lit_sat_cnt", 0, int'(d_cnt[0]), 7);
    chk("lit_sat_ovf", 0, int'(d_ovf[0]), 1);
    step(0, 0, 8'h00, 8'h00);
    chk("lit_hold_cnt", 0, int'(d_cnt[0]), 7);
    chk("lit_hold_ovf", 0, int'(d_ovf[0]), 1);

    // Wrap on B: 6 + 3 -> 1, then 1 - 2 -> 7.
    step(1, 0, 8'h00, 8'h00);
    step(0, 0, 8'b001, 8'h00);
    step(0, 0, 8'b111, 8'h00);
    chk("lit_wrap_cnt", 1, int'(d_cnt[1]), 1);
    chk("lit_wrap_ovf", 1, int'(d_ovf[1]), 1);
    step(0, 0, 8'h00, 8'b11);
    chk("lit_wrapd_cnt", 1, int'(d_cnt[1]), 7);
    chk("lit_wrapd_unf", 1, int'(d_unf[1]), 1);

    // Clear with up/down on A (A is 5 with overflow set here).
    step(0, 0, 8'b001, 8'h00);
    chk("lit_pre_clr_cnt", 0, int'(d_cnt[0]), 6);
    chk("lit_pre_clr_ovf", 0, int'(d_ovf[0]), 1);
    step(0, 1, 8'b011, 8'b01);
    chk("lit_clr_cnt", 0, int'(d_cnt[0]), 1);
    chk("lit_clr_ovf", 0, int'(d_ovf[0]), 0);
    chk("lit_clr_th",  0, int'(d_th[0]),  0);

    // Net-zero at both bounds on A.
    step(0, 0, 8'h00, 8'b01);
    step(0, 0, 8'b001, 8'b01);
    chk("lit_nz0_cnt", 0, int'(d_cnt[0]), 0);
    chk("lit_nz0_unf", 0, int'(d_unf[0]), 0);
    step(0, 0, 8'b111, 8'h00);
    step(0, 0, 8'b111, 8'h00);
    step(0, 0, 8'b001, 8'h00);
    step(0, 0, 8'b001, 8'b01);
    chk("lit_nz7_cnt", 0, int'(d_cnt[0]), 7);
    chk("lit_nz7_ovf", 0, int'(d_ovf[0]), 0);

    // Randomised run with biased phases to reach both bounds often.
    mode = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) mode = int'($urandom_range(0, 2));
      u = 8'($urandom);
      d = 8'($urandom);
      if (mode == 1) d = d & 8'($urandom);
      if (mode == 2) u = u & 8'($urandom);
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 15) == 0);
      if (i == 5000) r = 1'b1;
      step(r, c, u, d);
      if (i == 5000) begin
        chk("lit_mid_rst_cnt", 0, int'(d_cnt[0]), 5);
        chk("lit_mid_rst_th",  0, int'(d_th[0]),  1);
        chk("lit_mid_rst_ovf", 0, int'(d_ovf[0]), 0);
        chk("lit_mid_rst_unf", 0, int'(d_unf[0]), 0);
        chk("lit_mid_rst_cntE", 4, int'(d_cnt[4]), 12);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
